// File: rtl/store_align_if.sv
// Store request channel (MEM stage side) and word-write channel (data memory side)
// of the store alignment unit, bundled for port connection.
interface store_align_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_type;
  logic        mem_valid;
  logic        mem_ready;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport slave (
    input  req_valid, req_addr, req_data, req_type, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_addr, req_data, req_type, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_align_unit.sv
// Byte-lane alignment of SB/SH/SW stores into word-addressed writes with byte enables;
// word-crossing stores become two consecutive beats (or are dropped with err).
module store_align_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  store_align_if.slave bus,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      state_p, state_n;
  logic        split_p;
  logic [29:0] b1_addr_p;
  logic [31:0] b1_wdata_p;
  logic [3:0]  b1_be_p;

  logic [1:0]  off;
  logic [3:0]  base_mask;
  logic [6:0]  mask7;
  logic [63:0] d64;
  logic        need_b1, is_store, accept, drop, load, mem_hs, last_hs;

  function automatic logic [3:0] size_mask(input logic [1:0] t);
    case (t)
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0011;
      2'b11:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Unused bytes of rs2 are cleared before shifting so disabled lanes read as zero.
  function automatic logic [63:0] align_data(input logic [31:0] d, input logic [3:0] m,
                                             input logic [1:0] o);
    logic [31:0] dm;
    dm = d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return {32'b0, dm} << {o, 3'b000};
  endfunction

  // Request decode
  assign off       = bus.req_addr[1:0];
  assign base_mask = size_mask(bus.req_type);
  assign mask7     = {3'b000, base_mask} << off;
  assign d64       = align_data(bus.req_data, base_mask, off);
  assign need_b1   = |mask7[6:4];
  assign is_store  = (bus.req_type != 2'b00);
  assign accept    = bus.req_valid && bus.req_ready;
  assign drop      = accept && is_store && need_b1 && !ALLOW_MISALIGNED;
  assign load      = accept && is_store && !drop;
  assign mem_hs    = bus.mem_valid && bus.mem_ready;
  assign last_hs   = mem_hs && ((state_p == BEAT1) || ((state_p == BEAT0) && !split_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p <= IDLE;
      split_p <= 1'b0;
    end else begin
      state_p <= state_n;
      if (load) split_p <= need_b1;
    end
  end

  always_comb begin
    state_n = state_p;
    case (state_p)
      IDLE:    if (load) state_n = BEAT0;
      BEAT0:   if (mem_hs) state_n = split_p ? BEAT1 : (load ? BEAT0 : IDLE);
      BEAT1:   if (mem_hs) state_n = load ? BEAT0 : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_valid = (state_p != IDLE);
    bus.req_ready = (state_p == IDLE) || last_hs;
    busy          = (state_p != IDLE);
  end

  // Beat registers: beat 0 loads at acceptance, beat 1 is parked until beat 0 handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      err           <= 1'b0;
    end else begin
      err <= drop;
      if (load) begin
        bus.mem_addr  <= bus.req_addr[31:2];
        bus.mem_wdata <= d64[31:0];
        bus.mem_be    <= mask7[3:0];
      end else if ((state_p == BEAT0) && mem_hs && split_p) begin
        bus.mem_addr  <= b1_addr_p;
        bus.mem_wdata <= b1_wdata_p;
        bus.mem_be    <= b1_be_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      b1_addr_p  <= bus.req_addr[31:2] + 30'd1;
      b1_wdata_p <= d64[63:32];
      b1_be_p    <= {1'b0, mask7[6:4]};
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: expected beats are queued at issue and
// a negedge monitor pops and compares each memory handshake.
module tb_store_align_unit;
  logic clk = 1'b0;
  logic rst;
  logic busya, erra, busyb, errb;

  store_align_if ifa ();
  store_align_if ifb ();

  store_align_unit #(.ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .busy(busya), .err(erra));
  store_align_unit #(.ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .busy(busyb), .err(errb));

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  beat_t exp_q[$];
  int    hs_times[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  logic        have_hold = 1'b0;
  logic [65:0] hold_val;
  beat_t       e;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    beat_t b;
    b.a = a; b.d = d; b.be = be;
    exp_q.push_back(b);
  endtask

  // Monitor: compares every handshaked beat and checks stability under backpressure.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      have_hold = 1'b0;
    end else if (ifa.mem_valid) begin
      if (have_hold)
        chk("hold_stable", {ifa.mem_addr, ifa.mem_wdata, ifa.mem_be}, hold_val);
      if (ifa.mem_ready) begin
        hs_times.push_back(cyc);
        have_hold = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got addr 0x%0h be 0x%0h, required none",
                   ifa.mem_addr, ifa.mem_be);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 66'(ifa.mem_addr), 66'(e.a));
          chk("beat_be", 66'(ifa.mem_be), 66'(e.be));
          chk("beat_wdata", 66'(ifa.mem_wdata), 66'(e.d));
        end
      end else begin
        have_hold = 1'b1;
        hold_val  = {ifa.mem_addr, ifa.mem_wdata, ifa.mem_be};
      end
    end else begin
      have_hold = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    ifa.req_valid = 1'b1;
    ifa.req_type  = t;
    ifa.req_addr  = a;
    ifa.req_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifa.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_accept_timeout: got req_ready 0, required 1");
    end
    @(posedge clk);
    #1;
    ifa.req_valid = 1'b0;
    ifa.req_type  = 2'b11;
    ifa.req_addr  = 32'hFFFF_FFFF;
    ifa.req_data  = 32'h5A5A_5A5A;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(name, 66'(exp_q.size()), 66'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_type = 2'b00; ifa.req_addr = '0; ifa.req_data = '0;
    ifa.mem_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_type = 2'b00; ifb.req_addr = '0; ifb.req_data = '0;
    ifb.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_outputs", {ifa.mem_valid, ifa.mem_addr, ifa.mem_wdata, ifa.mem_be},
        {1'b0, 30'd0, 32'd0, 4'd0});
    chk("rst_ctrl", {busya, erra, ifa.req_ready}, {1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;

    // Aligned SW
    push(30'h40, 32'hDEADBEEF, 4'b1111);
    send(2'b11, 32'h100, 32'hDEADBEEF);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busya) cnt++;
    end
    chk("sw_busy_cycles", 66'(cnt), 66'd1);
    drain("sw_drain");

    // SB into lane 2
    push(30'h40, 32'h00FF0000, 4'b0100);
    send(2'b01, 32'h102, 32'hABCD12FF);
    drain("sb_drain");

    // SH split across words, beats in consecutive cycles
    hs_times.delete();
    push(30'h40, 32'hCD000000, 4'b1000);
    push(30'h41, 32'h000000AB, 4'b0001);
    send(2'b10, 32'h103, 32'h1234ABCD);
    drain("sh_split_drain");
    if (hs_times.size() == 2) chk("sh_split_gap", 66'(hs_times[1] - hs_times[0]), 66'd1);
    else chk("sh_split_beats", 66'(hs_times.size()), 66'd2);

    // SW split at top of address space, 3 stall cycles on beat 0
    push(30'h3FFFFFFF, 32'h22334400, 4'b1110);
    push(30'h0, 32'h00000011, 4'b0001);
    ifa.mem_ready = 1'b0;
    send(2'b11, 32'hFFFFFFFD, 32'h11223344);
    repeat (3) @(posedge clk);
    #1 ifa.mem_ready = 1'b1;
    drain("sw_wrap_drain");

    // Back-to-back aligned stores, no idle gap
    hs_times.delete();
    push(30'h0, 32'hA1A2A3A4, 4'b1111);
    push(30'h1, 32'hB1B2B3B4, 4'b1111);
    send(2'b11, 32'h0, 32'hA1A2A3A4);
    send(2'b11, 32'h4, 32'hB1B2B3B4);
    drain("b2b_drain");
    if (hs_times.size() == 2) chk("b2b_gap", 66'(hs_times[1] - hs_times[0]), 66'd1);
    else chk("b2b_beats", 66'(hs_times.size()), 66'd2);

    // No-op request
    send(2'b00, 32'h200, 32'h12345678);
    @(negedge clk);
    chk("noop_idle", {busya, ifa.mem_valid, erra}, 3'b000);
    @(posedge clk);
    #1;

    // Dropped misaligned store on the non-splitting instance
    ifb.req_valid = 1'b1; ifb.req_type = 2'b10; ifb.req_addr = 32'h3; ifb.req_data = 32'h1234;
    @(negedge clk);
    chk("drop_ready", 66'(ifb.req_ready), 66'd1);
    @(posedge clk);
    #1 ifb.req_valid = 1'b0;
    @(negedge clk);
    chk("drop_err_pulse", {errb, busyb, ifb.mem_valid}, 3'b100);
    @(negedge clk);
    chk("drop_err_clear", {errb, busyb, ifb.mem_valid}, 3'b000);
    @(negedge clk);
    chk("drop_no_beat", {errb, busyb, ifb.mem_valid}, 3'b000);
    @(posedge clk);
    #1;

    // Reset during BEAT0 of a split store abandons beat 1
    ifa.mem_ready = 1'b0;
    send(2'b10, 32'h103, 32'h1234ABCD);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifa.mem_ready = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {ifa.mem_valid, ifa.mem_addr, ifa.mem_wdata, ifa.mem_be},
        {1'b0, 30'd0, 32'd0, 4'd0});
    chk("midrst_ctrl", {busya, erra, ifa.req_ready}, {1'b0, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    chk("midrst_no_beat1", {ifa.mem_valid, busya}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required summary before timeout");
    $fatal(1, "watchdog");
  end
endmodule
